// File: rtl/alu_seq_flags_if.sv
// Request/response bundle for alu_seq_flags: operands and opcode in,
// registered result, flags and status out.
interface alu_seq_flags_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] Ea;
    logic [WIDTH-1:0] Eb;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output start, op, Ea, Eb,
        input  result, flags, busy, done
    );

    modport slave (
        input  start, op, Ea, Eb,
        output result, flags, busy, done
    );
endinterface

// File: rtl/alu_seq_flags.sv
// Registered ALU with {Z,N,V,C} flags. Logic ops complete in one cycle;
// shifts iterate one bit per cycle under a two-state FSM.
module alu_seq_flags #(
    parameter int unsigned WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_flags_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned FW  = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    state_e           state_q,  state_d;
    op_e              sop_q,    sop_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [SHW-1:0]   cnt_q,    cnt_d;
    logic             cacc_q,   cacc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [FW-1:0]    flags_q,  flags_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_v_c;
    logic             alu_cy_c;
    logic [WIDTH-1:0] shifted_c;
    logic             out_bit_c;
    logic             a_s_c;
    logic             b_s_c;

    // Single-cycle datapath for ADD..XOR; borrow of SUB lands in diff_c[WIDTH].
    always_comb begin
        sum_c     = {1'b0, bus.Ea} + {1'b0, bus.Eb};
        diff_c    = {1'b0, bus.Ea} - {1'b0, bus.Eb};
        a_s_c     = bus.Ea[WIDTH-1];
        b_s_c     = bus.Eb[WIDTH-1];
        alu_res_c = '0;
        alu_v_c   = 1'b0;
        alu_cy_c  = 1'b0;
        case (op_e'(bus.op))
            OP_ADD: begin
                alu_res_c = sum_c[WIDTH-1:0];
                alu_cy_c  = sum_c[WIDTH];
                alu_v_c   = (a_s_c == b_s_c) && (sum_c[WIDTH-1] != a_s_c);
            end
            OP_SUB: begin
                alu_res_c = diff_c[WIDTH-1:0];
                alu_cy_c  = diff_c[WIDTH];
                alu_v_c   = (a_s_c != b_s_c) && (diff_c[WIDTH-1] != a_s_c);
            end
            OP_AND:  alu_res_c = bus.Ea & bus.Eb;
            OP_OR:   alu_res_c = bus.Ea | bus.Eb;
            OP_XOR:  alu_res_c = bus.Ea ^ bus.Eb;
            default: alu_res_c = '0;
        endcase
    end

    // One-bit step of the latched shift; out_bit_c is the bit that falls off.
    always_comb begin
        shifted_c = acc_q;
        out_bit_c = 1'b0;
        case (sop_q)
            OP_SHL: begin
                shifted_c = {acc_q[WIDTH-2:0], 1'b0};
                out_bit_c = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                shifted_c = {1'b0, acc_q[WIDTH-1:1]};
                out_bit_c = acc_q[0];
            end
            OP_SRA: begin
                shifted_c = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                out_bit_c = acc_q[0];
            end
            default: begin
                shifted_c = acc_q;
                out_bit_c = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        sop_d    = sop_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        cacc_d   = cacc_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op >= 3'(OP_SHL)) begin
                        acc_d   = bus.Ea;
                        cnt_d   = bus.Eb[SHW-1:0];
                        cacc_d  = 1'b0;
                        sop_d   = op_e'(bus.op);
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res_c;
                        flags_d  = {(alu_res_c == '0), alu_res_c[WIDTH-1], alu_v_c, alu_cy_c};
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d  = shifted_c;
                    cacc_d = out_bit_c;
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    result_d = acc_q;
                    flags_d  = {(acc_q == '0), acc_q[WIDTH-1], 1'b0, cacc_q};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sop_q    <= OP_ADD;
            acc_q    <= '0;
            cnt_q    <= '0;
            cacc_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sop_q    <= sop_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            cacc_q   <= cacc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_seq_flags.sv
// Bench for alu_seq_flags at WIDTH=4 and WIDTH=8: directed spec cases, random
// ops against an arithmetic reference model, ignored starts and mid-shift reset.
module tb_alu_seq_flags;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_seq_flags_if #(.WIDTH(4)) bus4 ();
    alu_seq_flags_if #(.WIDTH(8)) bus8 ();

    alu_seq_flags #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    alu_seq_flags #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: returns {flags[3:0], result[7:0]} from plain integer arithmetic.
    function automatic logic [11:0] model(input int w, input int op, input int a, input int b);
        int mask = (1 << w) - 1;
        int half = 1 << (w - 1);
        int k    = b & (w - 1);
        int r    = 0;
        int v    = 0;
        int c    = 0;
        int sv;
        case (op)
            0: begin
                r = (a + b) & mask;
                c = ((a + b) > mask) ? 1 : 0;
                v = (((a >= half) == (b >= half)) && ((r >= half) != (a >= half))) ? 1 : 0;
            end
            1: begin
                r = (a - b + (1 << w)) & mask;
                c = (a < b) ? 1 : 0;
                v = (((a >= half) != (b >= half)) && ((r >= half) != (a >= half))) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                r = (a << k) & mask;
                c = (k == 0) ? 0 : ((a >> (w - k)) & 1);
            end
            6: begin
                r = a >> k;
                c = (k == 0) ? 0 : ((a >> (k - 1)) & 1);
            end
            default: begin
                sv = (a >= half) ? a - (1 << w) : a;
                r  = (sv >>> k) & mask;
                c  = (k == 0) ? 0 : ((a >> (k - 1)) & 1);
            end
        endcase
        model = {1'(r == 0), 1'(r >= half), 1'(v), 1'(c), 8'(r)};
    endfunction

    task automatic drive(input bit w8, input logic st, input int op, input int a, input int b);
        if (w8) begin
            bus8.start = st; bus8.op = 3'(op); bus8.Ea = 8'(a); bus8.Eb = 8'(b);
        end else begin
            bus4.start = st; bus4.op = 3'(op); bus4.Ea = 4'(a); bus4.Eb = 4'(b);
        end
    endtask

    task automatic sample(input bit w8, output int res, output int fl, output bit bsy, output bit dn);
        if (w8) begin
            res = int'(bus8.result); fl = int'(bus8.flags); bsy = bus8.busy; dn = bus8.done;
        end else begin
            res = int'(bus4.result); fl = int'(bus4.flags); bsy = bus4.busy; dn = bus4.done;
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency, busy span, result, flags, pulse width.
    task automatic run_op(input bit w8, input int op, input int a, input int b, input string tag);
        int          w       = w8 ? 8 : 4;
        logic [11:0] exp     = model(w, op, a, b);
        int          k       = b & (w - 1);
        int          lat_exp = (op >= 5) ? k + 2 : 1;
        int          lat     = 0;
        int          bcyc    = 0;
        int          res, fl;
        bit          bsy, dn;
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        do begin
            @(negedge clk);
            drive(w8, 1'b0, int'($urandom_range(0, 7)), int'($urandom), int'($urandom));
            lat++;
            sample(w8, res, fl, bsy, dn);
            if (!dn && bsy) bcyc++;
        end while (!dn && lat < 64);
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " busy_cycles"}, 32'(bcyc), 32'((op >= 5) ? k + 1 : 0));
        check({tag, " result"}, 32'(res), 32'(exp[7:0]));
        check({tag, " flags"}, 32'(fl), 32'(exp[11:8]));
        check({tag, " busy_at_done"}, 32'(bsy), 32'(0));
        @(negedge clk);
        sample(w8, res, fl, bsy, dn);
        check({tag, " done_dropped"}, 32'(dn), 32'(0));
        check({tag, " result_held"}, 32'(res), 32'(exp[7:0]));
    endtask

    // Spec-anchored constant check on the held outputs.
    task automatic expect_held(input bit w8, input int r, input int f, input string tag);
        int res, fl;
        bit bsy, dn;
        sample(w8, res, fl, bsy, dn);
        check({tag, " const_result"}, 32'(res), 32'(r));
        check({tag, " const_flags"}, 32'(fl), 32'(f));
    endtask

    initial begin
        int res, fl, dn_cnt, done_at, w, a, b, op;
        bit bsy, dn, w8;
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and no spurious done
        dn_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample(1'b0, res, fl, bsy, dn);
            if (dn) dn_cnt++;
        end
        check("reset result", 32'(res), 32'(0));
        check("reset flags", 32'(fl), 32'(0));
        check("reset busy", 32'(bsy), 32'(0));
        check("reset no_done", 32'(dn_cnt), 32'(0));

        // Directed cases at WIDTH=4
        run_op(1'b0, 0, 5, 3, "add5+3");   expect_held(1'b0, 8, 4'b0110, "add5+3");
        run_op(1'b0, 0, 15, 1, "add15+1"); expect_held(1'b0, 0, 4'b1001, "add15+1");
        run_op(1'b0, 1, 3, 5, "sub3-5");   expect_held(1'b0, 14, 4'b0101, "sub3-5");
        run_op(1'b0, 1, 5, 3, "sub5-3");   expect_held(1'b0, 2, 4'b0000, "sub5-3");
        run_op(1'b0, 2, 5, 3, "and");      expect_held(1'b0, 1, 4'b0000, "and");
        run_op(1'b0, 3, 5, 3, "or");       expect_held(1'b0, 7, 4'b0000, "or");
        run_op(1'b0, 4, 5, 5, "xor");      expect_held(1'b0, 0, 4'b1000, "xor");
        run_op(1'b0, 5, 5, 3, "shl_k3");   expect_held(1'b0, 8, 4'b0100, "shl_k3");
        run_op(1'b0, 7, 8, 2, "sra_k2");   expect_held(1'b0, 14, 4'b0100, "sra_k2");
        run_op(1'b0, 6, 3, 1, "shr_k1");   expect_held(1'b0, 1, 4'b0001, "shr_k1");
        run_op(1'b0, 5, 9, 0, "shl_k0");   expect_held(1'b0, 9, 4'b0100, "shl_k0");

        // Overflow cases at WIDTH=8
        run_op(1'b1, 0, 127, 1, "w8 add127+1"); expect_held(1'b1, 128, 4'b0110, "w8 add127+1");
        run_op(1'b1, 1, 128, 1, "w8 sub128-1"); expect_held(1'b1, 127, 4'b0010, "w8 sub128-1");
        run_op(1'b1, 7, 8'h90, 7, "w8 sra_k7");

        // Starts while busy are ignored; single done at k+2
        run_op(1'b0, 0, 5, 3, "pre_ign");
        @(negedge clk);
        drive(1'b0, 1'b1, 5, 4'b0101, 3);
        dn_cnt  = 0;
        done_at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 3) drive(1'b0, 1'b1, 0, 15, 1);
            else        drive(1'b0, 1'b0, 0, 0, 0);
            sample(1'b0, res, fl, bsy, dn);
            if (dn) begin dn_cnt++; done_at = i; end
            if (i <= 4) begin
                check("ign held_result", 32'(res), 32'(8));
                check("ign held_flags", 32'(fl), 32'(4'b0110));
            end
        end
        check("ign done_count", 32'(dn_cnt), 32'(1));
        check("ign done_cycle", 32'(done_at), 32'(5));
        check("ign result", 32'(res), 32'(8));
        check("ign flags", 32'(fl), 32'(4'b0100));

        // Reset during cycle 2 of a k=3 shift
        @(negedge clk);
        drive(1'b0, 1'b1, 5, 4'b0101, 3);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample(1'b0, res, fl, bsy, dn);
        check("midrst result", 32'(res), 32'(0));
        check("midrst flags", 32'(fl), 32'(0));
        check("midrst busy", 32'(bsy), 32'(0));
        check("midrst done", 32'(dn), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        dn_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample(1'b0, res, fl, bsy, dn);
            if (dn) dn_cnt++;
        end
        check("midrst no_done", 32'(dn_cnt), 32'(0));
        check("midrst idle_result", 32'(res), 32'(0));
        run_op(1'b0, 0, 2, 3, "post_rst_add");

        // Randomized ops on both widths
        for (int i = 0; i < 80; i++) begin
            w8 = 1'($urandom_range(0, 1));
            w  = w8 ? 8 : 4;
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, (1 << w) - 1));
            b  = int'($urandom_range(0, (1 << w) - 1));
            run_op(w8, op, a, b, $sformatf("rnd%0d w%0d op%0d a%0h b%0h", i, w, op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
